// File: rtl/rp_result_sequencer.sv
// Launches operand pairs into a fixed-latency rp stage and queues results in a FWFT FIFO.
// Define RP_OP_COUNTER_EN to add the wrapping op_count output.
module rp_result_sequencer #(
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    input  logic        decouple,
    output logic [31:0] ain,
    output logic [31:0] bin,
    input  logic [31:0] rp_result,
    output logic        busy,
    output logic        res_valid,
    output logic [31:0] res_data,
    input  logic        res_ready,
    output logic [4:0]  fifo_count,
    output logic        err
`ifdef RP_OP_COUNTER_EN
    ,
    output logic [15:0] op_count
`endif
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        CAPTURE
    } state_t;

    state_t        state;
    state_t        state_d;
    logic [3:0]    cnt;
    logic [3:0]    cnt_d;
    logic          accept;
    logic          abort;
    logic          push;
    logic          pop;
    logic          pending;
    logic [5:0]    occ;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [4:0]    count;
    logic          err_q;

    // An in-flight op already owns a FIFO slot, so admission counts it.
    assign pending = (state != IDLE);
    assign occ     = {1'b0, count} + {5'd0, pending};
    assign accept  = start && (state == IDLE) && !decouple
                     && (occ < 6'(FIFO_DEPTH));
    assign abort   = decouple && (state != IDLE);
    assign push    = (state == CAPTURE) && !decouple;
    assign pop     = res_ready && (count != 5'd0);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_d = WAIT;
                    cnt_d   = 4'(LATENCY);
                end
            end
            WAIT: begin
                if (decouple) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state_d = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            err_q <= 1'b0;
            ain   <= 32'd0;
            bin   <= 32'd0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            err_q <= err_q | (start && !accept) | abort;
            if (accept) begin
                ain <= a_in;
                bin <= b_in;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 5'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the read side is masked while empty.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wr_ptr] <= rp_result;
        end
    end

`ifdef RP_OP_COUNTER_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            op_count <= 16'd0;
        end else if (push) begin
            op_count <= op_count + 16'd1;
        end
    end
`endif

    assign busy       = (state != IDLE);
    assign res_valid  = (count != 5'd0);
    assign res_data   = res_valid ? mem[rd_ptr] : 32'd0;
    assign fifo_count = count;
    assign err        = err_q;

endmodule

// File: tb/tb_rp_result_sequencer.sv
// Scoreboard bench for rp_result_sequencer: directed scenarios then random traffic.
// Expected results come from a timestamp-based model of ops and FIFO occupancy.
module tb_rp_result_sequencer;

    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        decouple = 1'b0;
    logic        res_ready = 1'b0;
    logic [31:0] ain;
    logic [31:0] bin;
    logic [31:0] rp_result;
    logic        busy;
    logic        res_valid;
    logic [31:0] res_data;
    logic [4:0]  fifo_count;
    logic        err;
`ifdef RP_OP_COUNTER_EN
    logic [15:0] op_count;
`endif

    rp_result_sequencer #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .start(start),
        .a_in(a_in),
        .b_in(b_in),
        .decouple(decouple),
        .ain(ain),
        .bin(bin),
        .rp_result(rp_result),
        .busy(busy),
        .res_valid(res_valid),
        .res_data(res_data),
        .res_ready(res_ready),
        .fifo_count(fifo_count),
        .err(err)
`ifdef RP_OP_COUNTER_EN
        ,
        .op_count(op_count)
`endif
    );

    always #5 Clk = ~Clk;

    // rp stage: a+b with two cycles of latency
    logic [31:0] d1;
    logic [31:0] d2;
    always @(posedge Clk) begin
        d1 <= ain + bin;
        d2 <= d1;
    end
    assign rp_result = d2;

    int          errors = 0;
    int          checks = 0;
    int          cyc_n = 0;
    bit          chk_en = 1'b0;
    bit          m_busy;
    int          m_push_at;
    int          m_occ;
    bit          m_err;
    int          m_ops;
    logic [31:0] m_ain;
    logic [31:0] m_bin;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc_n);
        end
    endtask

    task automatic step(input bit rst, input bit st, input logic [31:0] a,
                        input logic [31:0] b, input bit dec, input bit rdy);
        Reset     = rst;
        start     = st;
        a_in      = a;
        b_in      = b;
        decouple  = dec;
        res_ready = rdy;
        @(posedge Clk);
        cyc_n++;
        if (rst) begin
            m_busy = 0;
            m_occ  = 0;
            m_err  = 0;
            m_ops  = 0;
            m_ain  = '0;
            m_bin  = '0;
            exp_q.delete();
            chk_en = 1'b1;
        end else begin
            bit acc;
            acc = st && !m_busy && !dec && (m_occ < DEPTH);
            if (st && !acc) m_err = 1;
            if (rdy && m_occ > 0) m_occ--;
            if (m_busy) begin
                if (dec) begin
                    m_busy = 0;
                    m_err  = 1;
                    void'(exp_q.pop_back());
                end else if (cyc_n == m_push_at) begin
                    m_busy = 0;
                    m_occ++;
                    m_ops++;
                end
            end else if (acc) begin
                m_busy    = 1;
                m_push_at = cyc_n + LAT + 1;
                m_ain     = a;
                m_bin     = b;
                exp_q.push_back(a + b);
            end
        end
        #1;
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] b,
                      input bit rdy_cap);
        step(0, 1, a, b, 0, 0);
        repeat (LAT) step(0, 0, '0, '0, 0, 0);
        step(0, 0, '0, '0, 0, rdy_cap);
    endtask

    always @(negedge Clk) begin
        if (chk_en && !Reset) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("fifo_count", 32'(fifo_count), 32'(m_occ));
            chk("res_valid", 32'(res_valid), 32'(m_occ > 0));
            chk("err", 32'(err), 32'(m_err));
            chk("ain", ain, m_ain);
            chk("bin", bin, m_bin);
`ifdef RP_OP_COUNTER_EN
            chk("op_count", 32'(op_count), 32'(m_ops[15:0]));
`endif
        end
    end

    // Monitor: every pop the DUT takes must match the oldest expected result.
    always @(negedge Clk) begin
        if (chk_en && !Reset && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                chk("res_data_unexpected", res_data, 32'hdead_beef);
            end else begin
                chk("res_data", res_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        step(1, 0, '0, '0, 0, 0);
        step(1, 1, 32'd9, 32'd9, 1, 1);

        // basic op, 5+7
        op(32'd5, 32'd7, 0);
        step(0, 0, '0, '0, 0, 1);
        step(0, 0, '0, '0, 0, 0);

        // fill to depth then a rejected fifth start
        for (int i = 0; i < DEPTH; i++) op(32'(i + 100), 32'd1, 0);
        step(0, 1, 32'h5555, 32'h6666, 0, 0);
        step(0, 0, '0, '0, 0, 0);
        repeat (DEPTH + 1) step(0, 0, '0, '0, 0, 1);

        // abort one cycle after start
        step(1, 0, '0, '0, 0, 0);
        step(0, 1, 32'd3, 32'd4, 0, 0);
        step(0, 0, '0, '0, 1, 0);
        repeat (4) step(0, 0, '0, '0, 0, 0);

        // push and pop together in the capture cycle, across pointer wrap
        step(1, 0, '0, '0, 0, 0);
        for (int i = 1; i <= 3; i++) op(32'(i), 32'd0, 0);
        op(32'd4, 32'd0, 1);
        op(32'd5, 32'd0, 1);
        op(32'd6, 32'd0, 1);
        repeat (DEPTH + 1) step(0, 0, '0, '0, 0, 1);

        // reset during WAIT with two entries queued
        op(32'd20, 32'd1, 0);
        op(32'd30, 32'd1, 0);
        step(0, 1, 32'd40, 32'd1, 0, 0);
        step(0, 0, '0, '0, 0, 0);
        step(1, 0, '0, '0, 0, 0);
        op(32'd50, 32'd2, 0);
        step(0, 0, '0, '0, 0, 1);
        step(0, 0, '0, '0, 0, 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 499) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom, $urandom,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 1) == 1);
        end
        repeat (LAT + DEPTH + 4) step(0, 0, '0, '0, 0, 1);
        chk("drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
